// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine: S-box init, key schedule and keystream XOR of a length-prefixed
// plaintext into ciphertext memory. Optional macro ARC4_ENC_PT_CHECK_EN enables the printable check.
module arc4_encrypt #(
  parameter int KEYLEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren,
  output logic        pt_bad
);

  localparam logic [1:0] KLAST = 2'(KEYLEN - 1);

  typedef enum logic [2:0] {IDLE, INIT, KSA, LEN0, LEN1, PRGA_A, PRGA_B, DONE} state_t;

  state_t      state;
  logic [7:0]  sbox [256];
  logic [7:0]  i_q, j_q, z_q, len_q;
  logic [1:0]  kidx_q;
  logic [23:0] key_q;

  logic [7:0]  key_byte, ksa_j, prga_i, prga_j, pad_idx, pad, z_nxt;

  always_comb begin
    case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
    ksa_j   = j_q + sbox[i_q] + key_byte;
    prga_i  = i_q + 8'd1;
    prga_j  = j_q + sbox[prga_i];
    // i/j already hold the post-swap positions when PRGA_B evaluates the pad
    pad_idx = sbox[i_q] + sbox[j_q];
    pad     = sbox[pad_idx];
    z_nxt   = z_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      ct_wren   <= 1'b0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      pt_addr   <= 8'd0;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      z_q       <= 8'd0;
      len_q     <= 8'd0;
      kidx_q    <= 2'd0;
    end else begin
      ct_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_q <= key;
            rdy   <= 1'b0;
            i_q   <= 8'd0;
            state <= INIT;
          end
        end
        INIT: begin
          sbox[i_q] <= i_q;
          i_q       <= i_q + 8'd1;
          if (i_q == 8'd255) begin
            j_q    <= 8'd0;
            kidx_q <= 2'd0;
            state  <= KSA;
          end
        end
        KSA: begin
          sbox[i_q]   <= sbox[ksa_j];
          sbox[ksa_j] <= sbox[i_q];
          j_q         <= ksa_j;
          i_q         <= i_q + 8'd1;
          kidx_q      <= (kidx_q == KLAST) ? 2'd0 : kidx_q + 2'd1;
          if (i_q == 8'd255) begin
            pt_addr <= 8'd0;
            state   <= LEN0;
          end
        end
        LEN0: state <= LEN1;
        LEN1: begin
          len_q     <= pt_rddata;
          ct_addr   <= 8'd0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          i_q       <= 8'd0;
          j_q       <= 8'd0;
          z_q       <= 8'd1;
          if (pt_rddata <= 8'd1) begin
            state <= DONE;
          end else begin
            pt_addr <= 8'd1;
            state   <= PRGA_A;
          end
        end
        PRGA_A: begin
          i_q          <= prga_i;
          j_q          <= prga_j;
          sbox[prga_i] <= sbox[prga_j];
          sbox[prga_j] <= sbox[prga_i];
          state        <= PRGA_B;
        end
        PRGA_B: begin
          ct_addr   <= z_q;
          ct_wrdata <= pt_rddata ^ pad;
          ct_wren   <= 1'b1;
          z_q       <= z_nxt;
          if (z_nxt == len_q) begin
            state <= DONE;
          end else begin
            pt_addr <= z_nxt;
            state   <= PRGA_A;
          end
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARC4_ENC_PT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pt_bad <= 1'b0;
    end else if (state == IDLE && en) begin
      pt_bad <= 1'b0;
    end else if (state == PRGA_B && (pt_rddata < 8'h20 || pt_rddata > 8'h7E)) begin
      pt_bad <= 1'b1;
    end
  end
`else
  assign pt_bad = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: randomized messages/keys against a plain ARC4 software model.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst, en, rdy, ct_wren, pt_bad;
  logic [23:0] key;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  exp_ct [256];
  logic [7:0]  wr_log [$];
  int          n_cmp = 0;
  int          n_err = 0;

  arc4_encrypt #(.KEYLEN(3)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren), .pt_bad(pt_bad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  always @(posedge clk) begin
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      wr_log.push_back(ct_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook ARC4: expected ciphertext of src (src[0] is the length) into exp_ct
  task automatic model(input logic [23:0] k, input logic [7:0] src [256]);
    int s [256];
    int kb [3];
    int j, t, ii, len;
    kb[0] = int'(k[23:16]); kb[1] = int'(k[15:8]); kb[2] = int'(k[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(src[0]);
    exp_ct[0] = src[0];
    ii = 0; j = 0;
    for (int z = 1; z < len; z++) begin
      ii = (ii + 1) % 256;
      j  = (j + s[ii]) % 256;
      t = s[ii]; s[ii] = s[j]; s[j] = t;
      exp_ct[z] = src[z] ^ 8'(s[(s[ii] + s[j]) % 256]);
    end
  endtask

  task automatic fill_pt(input int len, input bit printable);
    pt_mem[0] = 8'(len);
    for (int z = 1; z < 256; z++)
      pt_mem[z] = printable ? 8'(32 + $urandom_range(0, 94)) : 8'($urandom);
  endtask

  task automatic run(input logic [23:0] k, input bit disturb);
    int len, cyc, start, exp_cyc, nwr, mx;
    logic exp_bad;
    len = int'(pt_mem[0]);
    model(k, pt_mem);
    exp_bad = 1'b0;
`ifdef ARC4_ENC_PT_CHECK_EN
    for (int z = 1; z < len; z++)
      if (pt_mem[z] < 8'h20 || pt_mem[z] > 8'h7E) exp_bad = 1'b1;
`endif
    start = wr_log.size();
    @(negedge clk);
    key = k; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk("rdy_drop", 32'(rdy), 32'd0);
    chk("pt_bad_clear", 32'(pt_bad), 32'd0);
    cyc = 0;
    while (!rdy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 600) begin
        key = ~k; en = 1'b1;
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
    exp_cyc = 515 + 2 * ((len > 1) ? len - 1 : 0);
    chk("rdy_time", 32'(cyc), 32'(exp_cyc));
    nwr = wr_log.size() - start;
    chk("wr_count", 32'(nwr), 32'((len == 0) ? 1 : len));
    mx = 0;
    for (int n = start; n < wr_log.size(); n++) if (int'(wr_log[n]) > mx) mx = int'(wr_log[n]);
    chk("max_addr", 32'(mx), 32'((len == 0) ? 0 : len - 1));
    for (int z = 0; z < ((len == 0) ? 1 : len); z++)
      chk($sformatf("ct[%0d]", z), 32'(ct_mem[z]), 32'(exp_ct[z]));
    chk("pt_bad", 32'(pt_bad), 32'(exp_bad));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; key = 24'd0;
    for (int z = 0; z < 256; z++) begin pt_mem[z] = 8'd0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_wren", 32'(ct_wren), 32'd0);
    chk("rst_pt_bad", 32'(pt_bad), 32'd0);
    chk("rst_ct_addr", 32'(ct_addr), 32'd0);
    chk("rst_pt_addr", 32'(pt_addr), 32'd0);
    @(negedge clk); rst = 1'b0;

    fill_pt(8'h35, 1'b1);
    run(24'h1E4600, 1'b0);
    chk("ct0_len", 32'(ct_mem[0]), 32'h35);

    // round trip: decrypting DUT ciphertext with the same key yields the plaintext
    fill_pt(8'h20, 1'b1);
    run(24'h000018, 1'b0);
    model(24'h000018, ct_mem);
    for (int z = 1; z < 8'h20; z++) chk("roundtrip", 32'(exp_ct[z]), 32'(pt_mem[z]));

    fill_pt(0, 1'b1); run(24'($urandom), 1'b0);
    fill_pt(1, 1'b1); run(24'($urandom), 1'b0);
    fill_pt(2, 1'b0); run(24'($urandom), 1'b0);

    // reset in the middle of the key schedule
    fill_pt(8'h30, 1'b1);
    @(negedge clk); key = 24'h123456; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    repeat (300) @(posedge clk);
    n = wr_log.size();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy", 32'(rdy), 32'd1);
    chk("midrst_wren", 32'(ct_wren), 32'd0);
    @(negedge clk); rst = 1'b0;
    chk("midrst_nowr", 32'(wr_log.size()), 32'(n));
    run(24'hFFFFFF, 1'b0);

    // key change and en pulse while in PRGA
    fill_pt(8'h40, 1'b1);
    run(24'($urandom), 1'b1);
    n = wr_log.size();
    repeat (20) @(posedge clk);
    #1;
    chk("no_rerun_rdy", 32'(rdy), 32'd1);
    chk("no_rerun_wr", 32'(wr_log.size()), 32'(n));

    // newline at z=5
    fill_pt(8'h10, 1'b1);
    pt_mem[5] = 8'h0A;
    run(24'($urandom), 1'b0);
    fill_pt(8'h08, 1'b1);
    run(24'($urandom), 1'b0);

    for (int r = 0; r < 5; r++) begin
      fill_pt($urandom_range(0, 80), r[0]);
      run(24'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
